// File: rtl/disp_pipe_sched.sv
// Pixel sequencer for the fixed-latency disparity pipeline: tags, credits, drain.
// Optional sequence checker enabled with `define DISP_SCHED_CHECK_EN.
module disp_pipe_sched #(
  parameter int DIM_WIDTH  = 10,
  parameter int DELAY_DEEP = 13,
  parameter int FIFO_DEPTH = 32,
  parameter int OCC_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_WIDTH-1:0] img_width,
  input  logic [DIM_WIDTH-1:0] img_height,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 pipe_en,
  output logic [DIM_WIDTH-1:0] pipe_row,
  output logic [DIM_WIDTH-1:0] pipe_col,
  input  logic                 pipe_valid_out,
  input  logic [DIM_WIDTH-1:0] pipe_row_out,
  input  logic [DIM_WIDTH-1:0] pipe_col_out,
  input  logic                 fifo_pop,
  output logic [OCC_WIDTH-1:0] occ_level,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 seq_err
);

  localparam int TW = $clog2(DELAY_DEEP + 1);
  localparam logic [OCC_WIDTH-1:0] FULL = OCC_WIDTH'(FIFO_DEPTH);
  localparam logic [TW-1:0] DRAIN_LEN = TW'(DELAY_DEEP);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic [DIM_WIDTH-1:0] w_q, h_q, w_nxt, h_nxt;
  logic [DIM_WIDTH-1:0] row, col, row_nxt, col_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [OCC_WIDTH-1:0] occ;
  logic start_ok, accept, aborting, last_col, last_row;

  assign start_ok = (state == IDLE) & start
                  & (|img_width) & (|img_height);
  assign aborting = abort & ((state == RUN) | (state == DRAIN));
  // abort masks ready so the colliding pixel is never taken
  assign s_ready  = (state == RUN) & ~abort & (occ < FULL);
  assign accept   = s_valid & s_ready;
  assign last_col = (col == w_q - ONE);
  assign last_row = (row == h_q - ONE);

  assign pipe_en    = accept;
  assign pipe_row   = row;
  assign pipe_col   = col;
  assign occ_level  = occ;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    w_nxt     = w_q;
    h_nxt     = h_q;
    row_nxt   = row;
    col_nxt   = col;
    timer_nxt = timer;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          w_nxt     = img_width;
          h_nxt     = img_height;
          row_nxt   = '0;
          col_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          row_nxt   = '0;
          col_nxt   = '0;
          state_nxt = IDLE;
        end else if (accept) begin
          if (last_col) begin
            col_nxt = '0;
            row_nxt = row + ONE;
            if (last_row) begin
              timer_nxt = DRAIN_LEN;
              state_nxt = DRAIN;
            end
          end else begin
            col_nxt = col + ONE;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          row_nxt   = '0;
          col_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - T_ONE;
          if (timer == T_ONE) state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      w_q   <= '0;
      h_q   <= '0;
      row   <= '0;
      col   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      w_q   <= w_nxt;
      h_q   <= h_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      timer <= timer_nxt;
    end
  end

  // occupancy survives abort: in-flight pixels still land in the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else if (accept & ~fifo_pop) begin
      occ <= occ + OCC_WIDTH'(1);
    end else if (~accept & fifo_pop & (occ != '0)) begin
      occ <= occ - OCC_WIDTH'(1);
    end
  end

`ifdef DISP_SCHED_CHECK_EN
  logic [DIM_WIDTH-1:0] exp_row, exp_col;
  logic err;
  logic tag_bad;

  assign tag_bad = pipe_valid_out
                 & ((pipe_row_out != exp_row) | (pipe_col_out != exp_col));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_row <= '0;
      exp_col <= '0;
      err     <= 1'b0;
    end else begin
      if (start_ok | aborting) begin
        exp_row <= '0;
        exp_col <= '0;
      end else if (pipe_valid_out) begin
        if (exp_col == w_q - ONE) begin
          exp_col <= '0;
          exp_row <= exp_row + ONE;
        end else begin
          exp_col <= exp_col + ONE;
        end
      end
      if (tag_bad | (fifo_pop & (occ == '0))
          | (pipe_valid_out & (state == IDLE)))
        err <= 1'b1;
    end
  end

  assign seq_err = err;
`else
  logic unused_chk;
  assign unused_chk = ^{pipe_valid_out, pipe_row_out, pipe_col_out, aborting};
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_disp_pipe_sched.sv
// Self-checking bench for disp_pipe_sched: vector table, tag scoreboard,
// and hand sequences for backpressure, abort, async reset and the checker.
module tb_disp_pipe_sched;

  localparam int DW = 10;
  localparam int DD = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start, abort, s_valid, fifo_pop;
  logic [DW-1:0] img_width, img_height;

  logic s_ready, pipe_en, busy, frame_done, seq_err;
  logic [DW-1:0] pipe_row, pipe_col;
  logic [5:0] occ_level;

  logic s_ready4, pipe_en4, busy4, frame_done4, seq_err4;
  logic [DW-1:0] pipe_row4, pipe_col4;
  logic [2:0] occ4;

  logic pv_out;
  logic [DW-1:0] prow_out, pcol_out;

  disp_pipe_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .img_width(img_width), .img_height(img_height),
    .s_valid(s_valid), .s_ready(s_ready),
    .pipe_en(pipe_en), .pipe_row(pipe_row), .pipe_col(pipe_col),
    .pipe_valid_out(pv_out), .pipe_row_out(prow_out),
    .pipe_col_out(pcol_out), .fifo_pop(fifo_pop),
    .occ_level(occ_level), .busy(busy),
    .frame_done(frame_done), .seq_err(seq_err)
  );

  disp_pipe_sched #(.FIFO_DEPTH(4), .OCC_WIDTH(3)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .img_width(img_width), .img_height(img_height),
    .s_valid(s_valid), .s_ready(s_ready4),
    .pipe_en(pipe_en4), .pipe_row(pipe_row4), .pipe_col(pipe_col4),
    .pipe_valid_out(1'b0), .pipe_row_out('0),
    .pipe_col_out('0), .fifo_pop(fifo_pop),
    .occ_level(occ4), .busy(busy4),
    .frame_done(frame_done4), .seq_err(seq_err4)
  );

  // Behavioural delay pipeline; can corrupt the col tag of the 2nd pixel
  logic [DD-1:0] vsr;
  logic [DW-1:0] rsr [DD];
  logic [DW-1:0] csr [DD];
  int n_acc;
  logic corrupt = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr   <= '0;
      n_acc <= 0;
      for (int i = 0; i < DD; i++) begin
        rsr[i] <= '0;
        csr[i] <= '0;
      end
    end else begin
      vsr    <= {vsr[DD-2:0], pipe_en};
      rsr[0] <= pipe_row;
      csr[0] <= pipe_col ^ DW'((corrupt && pipe_en && n_acc == 1) ? 1 : 0);
      for (int i = 1; i < DD; i++) begin
        rsr[i] <= rsr[i-1];
        csr[i] <= csr[i-1];
      end
      if (pipe_en) n_acc <= n_acc + 1;
    end
  end

  assign pv_out   = vsr[DD-1];
  assign prow_out = rsr[DD-1];
  assign pcol_out = csr[DD-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; abort = 0; s_valid = 0; fifo_pop = 0;
    img_width = '0; img_height = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic chk_zero(input string pre);
    chk({pre, "_s_ready"}, int'(s_ready), 0);
    chk({pre, "_pipe_en"}, int'(pipe_en), 0);
    chk({pre, "_pipe_row"}, int'(pipe_row), 0);
    chk({pre, "_pipe_col"}, int'(pipe_col), 0);
    chk({pre, "_occ"}, int'(occ_level), 0);
    chk({pre, "_busy"}, int'(busy), 0);
    chk({pre, "_frame_done"}, int'(frame_done), 0);
    chk({pre, "_seq_err"}, int'(seq_err), 0);
  endtask

  task automatic start_frame(input int w, input int h);
    img_width  = DW'(w);
    img_height = DW'(h);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct packed {
    logic [DW-1:0] row;
    logic [DW-1:0] col;
  } tag_t;

  typedef struct {
    int w;
    int h;
    int busy;
  } vec_t;

  tag_t exp_q[$];

  initial begin
    vec_t tbl[5];
    tag_t e;
    int acc, t_last, ret_cyc, done_cyc, n_done, busy_ret, last_r, last_c;

    tbl[0] = '{w: 0, h: 2, busy: 0};
    tbl[1] = '{w: 3, h: 0, busy: 0};
    tbl[2] = '{w: 0, h: 0, busy: 0};
    tbl[3] = '{w: 2, h: 2, busy: 1};
    tbl[4] = '{w: 1, h: 1023, busy: 1};

    rst = 1'b1;
    #2;
    do_reset();
    #3;
    chk_zero("reset");
    step();

    // 1: 4x2 frame, tags, drain timing, frame_done pulse
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        e.row = DW'(r);
        e.col = DW'(c);
        exp_q.push_back(e);
      end
    start_frame(4, 2);
    s_valid = 1'b1;
    acc = 0; t_last = -100; ret_cyc = -1; done_cyc = -1;
    n_done = 0; busy_ret = 0;
    for (int k = 0; k < 40; k++) begin
      #3;
      if (pipe_en) begin
        if (exp_q.size() == 0) begin
          chk("t1_extra_accept", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("t1_row", int'(pipe_row), int'(e.row));
          chk("t1_col", int'(pipe_col), int'(e.col));
        end
        acc++;
        if (acc == 8) t_last = cyc;
      end
      if (cyc == t_last + 1) chk("t1_ready_drop", int'(s_ready), 0);
      if (pv_out && prow_out == 1 && pcol_out == 3) begin
        ret_cyc  = cyc;
        busy_ret = int'(busy);
      end
      if (frame_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      step();
    end
    s_valid = 1'b0;
    #3;
    chk("t1_accepts", acc, 8);
    chk("t1_ret_latency", ret_cyc - t_last, 13);
    chk("t1_busy_at_ret", busy_ret, 1);
    chk("t1_done_latency", done_cyc - t_last, 14);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_occ", int'(occ_level), 8);
    chk("t1_seq_err", int'(seq_err), 0);
    exp_q.delete();
    do_reset();

    // 2: credit backpressure on a 4-deep FIFO
    start_frame(8, 1);
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("t2_accept", int'(pipe_en4), 1);
      step();
    end
    #3;
    chk("t2_full_occ", int'(occ4), 4);
    chk("t2_full_ready", int'(s_ready4), 0);
    chk("t2_full_en", int'(pipe_en4), 0);
    fifo_pop = 1'b1;
    step();
    #3;
    chk("t2_pop_occ", int'(occ4), 3);
    chk("t2_pop_ready", int'(s_ready4), 1);
    step();
    fifo_pop = 1'b0;
    #3;
    chk("t2_acc_pop_occ", int'(occ4), 3);
    s_valid = 1'b0;
    do_reset();

    // 3: abort on the 3rd accept of a 4x4 frame
    start_frame(4, 4);
    s_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #3;
      chk("t3_accept", int'(pipe_en), 1);
      step();
    end
    abort = 1'b1;
    #3;
    chk("t3_abort_ready", int'(s_ready), 0);
    chk("t3_abort_en", int'(pipe_en), 0);
    step();
    abort = 1'b0;
    s_valid = 1'b0;
    #3;
    chk("t3_busy", int'(busy), 0);
    chk("t3_occ", int'(occ_level), 2);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (frame_done) n_done++;
      step();
    end
    chk("t3_no_done", n_done, 0);
    start_frame(4, 4);
    s_valid = 1'b1;
    #3;
    chk("t3_restart_en", int'(pipe_en), 1);
    chk("t3_restart_row", int'(pipe_row), 0);
    chk("t3_restart_col", int'(pipe_col), 0);
    step();
    s_valid = 1'b0;
    do_reset();

    // 4: start qualification table, then start while running
    for (int i = 0; i < 5; i++) begin
      start_frame(tbl[i].w, tbl[i].h);
      #3;
      chk($sformatf("t4_busy_%0d", i), int'(busy), tbl[i].busy);
      abort = 1'b1;
      step();
      abort = 1'b0;
    end
    start_frame(2, 2);
    s_valid = 1'b1;
    acc = 0; last_r = -1; last_c = -1;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        img_width = DW'(3);
        img_height = DW'(3);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      #3;
      if (pipe_en) begin
        acc++;
        last_r = int'(pipe_row);
        last_c = int'(pipe_col);
      end
      step();
    end
    s_valid = 1'b0;
    chk("t4_run_start_acc", acc, 4);
    chk("t4_last_row", last_r, 1);
    chk("t4_last_col", last_c, 1);
    do_reset();

    // 5: async reset in the middle of DRAIN
    start_frame(1, 1);
    s_valid = 1'b1;
    #3;
    chk("t5_accept", int'(pipe_en), 1);
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    #3;
    chk("t5_draining", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk_zero("t5_async");
    step();
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      #3;
      if (frame_done | busy) n_done++;
      step();
    end
    chk("t5_no_done", n_done, 0);
    do_reset();

    // 6: checker sets on a bad tag and on underflow
    corrupt = 1'b1;
    start_frame(4, 1);
    s_valid = 1'b1;
    for (int k = 0; k < 25; k++) step();
    s_valid = 1'b0;
    corrupt = 1'b0;
    #3;
`ifdef DISP_SCHED_CHECK_EN
    chk("t6_tag_err", int'(seq_err), 1);
`else
    chk("t6_tag_err_off", int'(seq_err), 0);
`endif
    for (int k = 0; k < 5; k++) step();
    #3;
`ifdef DISP_SCHED_CHECK_EN
    chk("t6_sticky", int'(seq_err), 1);
`else
    chk("t6_sticky_off", int'(seq_err), 0);
`endif
    do_reset();
    #3;
    chk("t6_cleared", int'(seq_err), 0);
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    #3;
`ifdef DISP_SCHED_CHECK_EN
    chk("t6_underflow_err", int'(seq_err), 1);
`else
    chk("t6_underflow_off", int'(seq_err), 0);
`endif
    chk("t6_underflow_occ", int'(occ_level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
